// File: rtl/rf_pkg.sv
// Shared register-file constants and the register index type used by decode,
// writeback and the register file itself.
package rf_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_DEPTH = 16;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0]    reg_idx_t;
    typedef logic [RF_WIDTH-1:0] reg_data_t;

    // Entry 0 is the hardwired zero register: never written, never pending.
    function automatic logic is_zero_reg(input reg_idx_t idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when an instruction
// claims the register as destination and cleared when writeback lands.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int  DEPTH  = RF_DEPTH,
    parameter bit  BYPASS = 1'b1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_addr,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          busy1,
    output logic          busy2
);

    logic [DEPTH-1:0] pending;
    logic             wr_live;
    logic             claim_live;

    assign wr_live    = wr_en && (wr_addr != '0);
    assign claim_live = claim_en && (claim_addr != '0);

    // The claim is applied after the clear so a new producer supersedes the
    // write retiring the old one when both target the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_live) begin
                pending[wr_addr] <= 1'b0;
            end
            if (claim_live) begin
                pending[claim_addr] <= 1'b1;
            end
        end
    end

    logic fwd1;
    logic fwd2;

    assign fwd1 = BYPASS && wr_live && (wr_addr == rd_addr1);
    assign fwd2 = BYPASS && wr_live && (wr_addr == rd_addr2);

    assign busy1 = pending[rd_addr1] && !fwd1;
    assign busy2 = pending[rd_addr2] && !fwd2;

endmodule

// File: rtl/regfile_sb.sv
// WISC register file: one write port, two read ports, hardwired-zero entry 0,
// optional write-to-read bypass and optional registered read data.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int  WIDTH    = RF_WIDTH,
    parameter int  DEPTH    = RF_DEPTH,
    parameter bit  BYPASS   = 1'b1,
    parameter bit  READ_REG = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_addr,
    output logic             busy1,
    output logic             busy2
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    logic [WIDTH-1:0] rd_comb1;
    logic [WIDTH-1:0] rd_comb2;

    // Entry 0 is forced to zero here as well, so it never depends on storage.
    always_comb begin
        rd_comb1 = '0;
        rd_comb2 = '0;
        if (rd_addr1 != '0) begin
            if (BYPASS && wr_live && (wr_addr == rd_addr1)) begin
                rd_comb1 = wr_data;
            end else begin
                rd_comb1 = mem[rd_addr1];
            end
        end
        if (rd_addr2 != '0) begin
            if (BYPASS && wr_live && (wr_addr == rd_addr2)) begin
                rd_comb2 = wr_data;
            end else begin
                rd_comb2 = mem[rd_addr2];
            end
        end
    end

    generate
        if (READ_REG) begin : g_rd_reg
            logic [WIDTH-1:0] rd_q1;
            logic [WIDTH-1:0] rd_q2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q1 <= '0;
                    rd_q2 <= '0;
                end else begin
                    rd_q1 <= rd_comb1;
                    rd_q2 <= rd_comb2;
                end
            end

            assign rd_data1 = rd_q1;
            assign rd_data2 = rd_q2;
        end else begin : g_rd_comb
            assign rd_data1 = rd_comb1;
            assign rd_data2 = rd_comb2;
        end
    endgenerate

    // Busy stays combinational in both read modes; decode samples it with the
    // address in the same cycle.
    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass/combinational and
// no-bypass/registered) share stimulus and are checked against one model.
`timescale 1ns/1ps
module tb_regfile_sb;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          claim_en;
    logic [AW-1:0] claim_addr;

    logic [W-1:0]  a_rd1, a_rd2, b_rd1, b_rd2;
    logic          a_busy1, a_busy2, b_busy1, b_busy2;

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1), .READ_REG(1'b0)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(a_rd1), .rd_addr2(rd_addr2), .rd_data2(a_rd2),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy1(a_busy1), .busy2(a_busy2)
    );

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b0), .READ_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(b_rd1), .rd_addr2(rd_addr2), .rd_data2(b_rd2),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy1(b_busy1), .busy2(b_busy2)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
        logic         a_b1, a_b2, b_b1, b_b2;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_mem [D];
    bit           m_pend [D];
    logic [W-1:0] prev_b1, prev_b2;
    int           tests = 0;
    int           fails = 0;

    function automatic logic [W-1:0] model_rd(input int addr, input bit byp);
        if (addr == 0) return '0;
        if (byp && wr_en && int'(wr_addr) == addr) return wr_data;
        return m_mem[addr];
    endfunction

    function automatic logic model_busy(input int addr, input bit byp);
        if (addr == 0) return 1'b0;
        if (byp && wr_en && int'(wr_addr) == addr) return 1'b0;
        return m_pend[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        prev_b1 = '0;
        prev_b2 = '0;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0; claim_en = 1'b0; claim_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One clock cycle: present inputs, push the outputs the model predicts for
    // this cycle, then apply the edge that ends the cycle to the model.
    task automatic cycle(input bit we, input int wa, input logic [W-1:0] wd,
                         input int ra1, input int ra2, input bit ce, input int ca);
        exp_t e;
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = AW'(wa); wr_data = wd;
        rd_addr1 = AW'(ra1); rd_addr2 = AW'(ra2);
        claim_en = ce; claim_addr = AW'(ca);
        e.a_rd1 = model_rd(ra1, 1'b1);
        e.a_rd2 = model_rd(ra2, 1'b1);
        e.a_b1  = model_busy(ra1, 1'b1);
        e.a_b2  = model_busy(ra2, 1'b1);
        e.b_b1  = model_busy(ra1, 1'b0);
        e.b_b2  = model_busy(ra2, 1'b0);
        e.b_rd1 = prev_b1;
        e.b_rd2 = prev_b2;
        exp_q.push_back(e);
        prev_b1 = model_rd(ra1, 1'b0);
        prev_b2 = model_rd(ra2, 1'b0);
        if (we && wa != 0) begin
            m_mem[wa]  = wd;
            m_pend[wa] = 1'b0;
        end
        if (ce && ca != 0) m_pend[ca] = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("a_rd_data1", a_rd1, e.a_rd1);
            check("a_rd_data2", a_rd2, e.a_rd2);
            check("a_busy1", W'(a_busy1), W'(e.a_b1));
            check("a_busy2", W'(a_busy2), W'(e.a_b2));
            check("b_rd_data1", b_rd1, e.b_rd1);
            check("b_rd_data2", b_rd2, e.b_rd2);
            check("b_busy1", W'(b_busy1), W'(e.b_b1));
            check("b_busy2", W'(b_busy2), W'(e.b_b2));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // basic write/read, unwritten register reads 0
        cycle(1, 3, 16'h1234, 0, 0, 0, 0);
        cycle(0, 0, 16'h0000, 3, 3, 0, 0);
        cycle(0, 0, 16'h0000, 5, 3, 0, 0);
        // zero register ignores writes and claims
        cycle(1, 0, 16'hBEEF, 0, 0, 0, 0);
        cycle(0, 0, 16'h0000, 0, 0, 1, 0);
        cycle(0, 0, 16'h0000, 0, 0, 0, 0);
        // same-cycle write/read bypass
        cycle(1, 7, 16'hA5A5, 7, 7, 0, 0);
        cycle(0, 0, 16'h0000, 7, 0, 0, 0);
        // registered read latency
        cycle(1, 4, 16'h0042, 0, 0, 0, 0);
        cycle(0, 0, 16'h0000, 0, 4, 0, 0);
        cycle(0, 0, 16'h0000, 0, 4, 0, 0);
        // scoreboard: claim, claim+write, write alone
        cycle(0, 0, 16'h0000, 2, 0, 1, 2);
        cycle(0, 0, 16'h0000, 2, 0, 0, 0);
        cycle(1, 2, 16'h0011, 2, 0, 1, 2);
        cycle(0, 0, 16'h0000, 2, 0, 0, 0);
        cycle(1, 2, 16'h0022, 2, 2, 0, 0);
        cycle(0, 0, 16'h0000, 2, 2, 0, 0);
        // claim and write to different registers in one cycle
        cycle(1, 6, 16'h0606, 6, 8, 1, 8);
        cycle(0, 0, 16'h0000, 6, 8, 0, 0);
        // asynchronous reset with r9 pending and holding 0xFFFF
        cycle(1, 9, 16'hFFFF, 0, 0, 0, 0);
        cycle(0, 0, 16'h0000, 9, 9, 1, 9);
        cycle(0, 0, 16'h0000, 9, 9, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_a_rd_data1", a_rd1, 16'h0000);
        check("rst_a_busy1", W'(a_busy1), 16'h0000);
        check("rst_b_rd_data1", b_rd1, 16'h0000);
        check("rst_b_busy2", W'(b_busy2), 16'h0000);
        do_reset();
        cycle(0, 0, 16'h0000, 9, 9, 0, 0);
        cycle(0, 0, 16'h0000, 9, 9, 0, 0);

        // randomized traffic with narrow address range to force collisions
        for (int n = 0; n < 500; n++) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7), 16'($urandom),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7));
        end
        cycle(0, 0, 16'h0000, 1, 2, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file for the WISC CPU datapath: one write port, two read ports, hardwired-zero entry 0.
- Selectable write-to-read bypass and optional registered read outputs.
- Per-entry pending-write scoreboard that decode uses to detect RAW hazards.
- Replaces the fixed 16x16 bitcell register array and its zero register with one synthesizable block.

Parameters:
WIDTH, 16, data width of each entry in bits.
DEPTH, 16, number of entries (power of two, >=2); entry 0 reads as zero.
AW, $clog2(DEPTH), address width (derived localparam, not overridable).
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the pre-write value.
READ_REG, 0, 0 = combinational read data; 1 = read data registered (1-cycle latency).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  write strobe.
wr_addr  in  AW  write address.
wr_data  in  WIDTH  write data.
rd_addr1  in  AW  read port 1 address.
rd_data1  out  WIDTH  read port 1 data.
rd_addr2  in  AW  read port 2 address.
rd_data2  out  WIDTH  read port 2 data.
claim_en  in  1  mark claim_addr as pending (instruction issued with this destination).
claim_addr  in  AW  destination being claimed.
busy1  out  1  entry at rd_addr1 is pending.
busy2  out  1  entry at rd_addr2 is pending.

Behaviour:
- Reset (async, on rst high):
  - All entries clear to 0 and all pending bits clear.
  - With READ_REG=1, rd_data1/rd_data2 registers clear to 0.
  - busy1/busy2 read 0 while reset is held.
- Write:
  - On a rising clk with wr_en=1 and wr_addr!=0, the entry takes wr_data.
  - Writes to address 0 are discarded, and entry 0 always reads 0.
- Combinational read (READ_REG=0):
  - rd_dataN = entry[rd_addrN].
  - If BYPASS=1, wr_en=1, wr_addr==rd_addrN and rd_addrN!=0, then rd_dataN = wr_data in the same cycle.
- Registered read (READ_REG=1):
  - rd_dataN is updated each edge with the value the combinational path would show in that cycle, including the bypass rule.
  - Data appears one cycle after the address is presented.
- Both ports are independent; the same address on both ports gives identical data.
- Scoreboard, one pending bit per entry, all updates on the clk edge:
  - claim_en=1 and claim_addr!=0 sets pending[claim_addr].
  - wr_en=1 and wr_addr!=0 clears pending[wr_addr].
  - claim and write to the same address in one cycle: the claim wins, pending stays 1 (a new producer supersedes the old one).
  - Claim and write to different addresses: both take effect.
  - pending[0] is constant 0, and a claim to address 0 is ignored.
- busyN, always combinational regardless of READ_REG:
  - busyN = pending[rd_addrN].
  - If BYPASS=1 and a write to rd_addrN occurs this cycle, busyN=0 because the data is forwarded.
  - If BYPASS=0, busyN stays 1 until the cycle after the write.
- Reset mid-operation: all pending bits and contents clear immediately, and any in-flight claims are lost.
- No X propagation: out-of-range addresses cannot occur (DEPTH is a power of two).

Decomposition:
- Package rf_pkg: default WIDTH/DEPTH constants and the reg-index typedef (logic [AW-1:0]) shared with decode and writeback.
- Sub-module rf_scoreboard holds the pending vector, set/clear priority and busy lookup (with the bypass override).
- The top level holds the storage array, write logic, bypass muxes and the optional output registers.

Test Plan:
1. Reset, then write 0x1234 to r3 and read r3 on both ports next cycle -> rd_data1=rd_data2=0x1234; read r5 -> 0x0000.
2. Write 0xBEEF to r0, then read r0 -> 0x0000; claim r0 -> busy stays 0.
3. BYPASS=1, READ_REG=0: write 0xA5A5 to r7 while rd_addr1=7 in the same cycle -> rd_data1=0xA5A5 that cycle. BYPASS=0: rd_data1 shows the old value, then 0xA5A5 next cycle.
4. READ_REG=1: present rd_addr2=4 (holding 0x0042) -> rd_data2=0x0042 exactly one cycle later; it is 0 immediately after reset.
5. Scoreboard sequence:
   - Claim r2 -> busy1(rd_addr1=2)=1 next cycle.
   - Claim r2 and write r2 (0x0011) in the same cycle -> busy1 remains 1.
   - Write r2 (0x0022) alone -> with BYPASS=1 busy1=0 in that cycle; with BYPASS=0 busy1=0 the following cycle.
6. Assert rst asynchronously, mid-cycle, with r9 pending and holding 0xFFFF -> busy and data drop to 0 before the next clk edge, and after release r9 reads 0.
